// File: rtl/dphy_rx_pkg.sv
// rtl/dphy_rx_pkg.sv - shared types and constants for the D-PHY HS receive path
// Contents:
//   SYNC_WORD      HS leader byte, serial order LSB first
//   rx_byte_t      payload byte type
//   rx_hs_state_e  deserializer FSM states
//   pick_byte      selects the aligned byte out of the shifted history
package dphy_rx_pkg;

    localparam logic [7:0] SYNC_WORD = 8'hB8;

    typedef logic [7:0] rx_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } rx_hs_state_e;

    // off==2 is the even alignment (byte in sr[9:2]), anything else is odd (sr[8:1]).
    function automatic rx_byte_t pick_byte(input logic [9:1] sr, input logic [1:0] off);
        return (off == 2'd2) ? sr[9:2] : sr[8:1];
    endfunction

endpackage

// File: rtl/rx_hs_sync_detect.sv
// rtl/rx_hs_sync_detect.sv - combinational dual-alignment HS sync byte compare
// Ports:
//   sr_n  in   9  next history value (bit 9 newest); bit 0 of the history never matters
//   hit   out  1  sync byte found at either alignment
//   off   out  2  2 = even alignment, 1 = odd alignment, 0 = no hit
module rx_hs_sync_detect
    import dphy_rx_pkg::*;
(
    input  logic [9:1] sr_n,
    output logic       hit,
    output logic [1:0] off
);

    // Even alignment wins when both windows match.
    always_comb begin
        hit = 1'b0;
        off = 2'd0;
        if (sr_n[9:2] == SYNC_WORD) begin
            hit = 1'b1;
            off = 2'd2;
        end else if (sr_n[8:1] == SYNC_WORD) begin
            hit = 1'b1;
            off = 2'd1;
        end
    end

endmodule

// File: rtl/rx_hs_deserializer.sv
// rtl/rx_hs_deserializer.sv - D-PHY HS receive deserializer with sync hunt
// Ports:
//   RxDDRClkHS    in   1  DDR bit clock, all logic on its rising edge
//   RxRst         in   1  synchronous active-high reset
//   rx_hs_en      in   1  HS receive window (level, SoT..EoT)
//   serial_B1     in   1  earlier bit of the current pair
//   serial_B2     in   1  later bit of the current pair
//   RxByteHS      out  8  payload byte, LSB = first received bit
//   RxValidHS     out  1  one-cycle strobe per completed byte
//   RxActiveHS    out  1  high while in DATA
//   RxSyncHS      out  1  one-cycle pulse on sync detection
//   ErrSotSyncHS  out  1  one-cycle pulse on hunt timeout
module rx_hs_deserializer
    import dphy_rx_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 64,
    parameter int TMO_W        = 7
)
(
    input  logic       RxDDRClkHS,
    input  logic       RxRst,
    input  logic       rx_hs_en,
    input  logic       serial_B1,
    input  logic       serial_B2,
    output logic [7:0] RxByteHS,
    output logic       RxValidHS,
    output logic       RxActiveHS,
    output logic       RxSyncHS,
    output logic       ErrSotSyncHS
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SYNC_TIMEOUT - 1);

    rx_hs_state_e     state_q, state_d;
    // Only bits 9:3 of the 10-bit history are ever read again after a shift;
    // bits 2:0 fall out of every compare window, so they are not stored.
    logic [9:3]       sr_q, sr_d;
    logic [9:1]       sr_n;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       off_q, off_d;
    rx_byte_t         byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             sync_q, sync_d;
    logic             err_q, err_d;

    logic             hit;
    logic [1:0]       hit_off;

    assign sr_n = {serial_B2, serial_B1, sr_q};

    rx_hs_sync_detect u_sync_detect (
        .sr_n (sr_n),
        .hit  (hit),
        .off  (hit_off)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        tmo_d   = tmo_q;
        phase_d = phase_q;
        off_d   = off_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        sync_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Pair presented in this cycle is deliberately not shifted.
                sr_d    = '0;
                tmo_d   = '0;
                phase_d = 2'd0;
                if (rx_hs_en) begin
                    state_d = HUNT;
                end
            end

            HUNT: begin
                if (!rx_hs_en) begin
                    state_d = IDLE;
                    sr_d    = '0;
                    tmo_d   = '0;
                end else begin
                    sr_d  = sr_n[9:3];
                    tmo_d = tmo_q + 1'b1;
                    if (hit) begin
                        off_d   = hit_off;
                        phase_d = 2'd0;
                        state_d = DATA;
                        sync_d  = 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            DATA: begin
                // A byte finishing on the same edge EoT is seen still gets delivered.
                if (phase_q == 2'd3) begin
                    byte_d  = pick_byte(sr_n, off_q);
                    valid_d = 1'b1;
                end
                if (!rx_hs_en) begin
                    state_d = IDLE;
                    sr_d    = '0;
                    phase_d = 2'd0;
                end else begin
                    sr_d    = sr_n[9:3];
                    phase_d = phase_q + 2'd1;
                end
            end

            ERR: begin
                if (!rx_hs_en) begin
                    state_d = IDLE;
                    sr_d    = '0;
                    tmo_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge RxDDRClkHS) begin
        if (RxRst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            tmo_q   <= '0;
            phase_q <= 2'd0;
            off_q   <= 2'd0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            tmo_q   <= tmo_d;
            phase_q <= phase_d;
            off_q   <= off_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
        end
    end

    assign RxByteHS     = byte_q;
    assign RxValidHS    = valid_q;
    assign RxActiveHS   = (state_q == DATA);
    assign RxSyncHS     = sync_q;
    assign ErrSotSyncHS = err_q;

endmodule

// File: tb/tb_rx_hs_deserializer.sv
// tb/tb_rx_hs_deserializer.sv - scoreboard bench for rx_hs_deserializer
module tb_rx_hs_deserializer;

    logic       clk;
    logic       rst;
    logic       rx_hs_en;
    logic       b1;
    logic       b2;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_sync;
    logic       err_sot;

    rx_hs_deserializer dut (
        .RxDDRClkHS   (clk),
        .RxRst        (rst),
        .rx_hs_en     (rx_hs_en),
        .serial_B1    (b1),
        .serial_B2    (b2),
        .RxByteHS     (rx_byte),
        .RxValidHS    (rx_valid),
        .RxActiveHS   (rx_active),
        .RxSyncHS     (rx_sync),
        .ErrSotSyncHS (err_sot)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   sync_cnt = 0;
    int   err_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Byte scoreboard: every strobe must match the oldest expectation in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", {24'h0, rx_byte}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("byte_val", {24'h0, rx_byte}, {24'h0, e.data});
                check("byte_cyc", cyc, e.cyc);
            end
        end
        if (rx_sync === 1'b1) sync_cnt++;
        if (err_sot === 1'b1) err_cnt++;
        if (rx_sync === 1'b1 && err_sot === 1'b1) check("sync_err_excl", 1, 0);
    end

    task automatic step(input logic en, input logic bit1, input logic bit2);
        rx_hs_en = en;
        b1       = bit1;
        b2       = bit2;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [63:0] bits, input int npairs, input logic en);
        for (int i = 0; i < npairs; i++) begin
            step(en, bits[2*i], bits[2*i+1]);
        end
    endtask

    // From IDLE: enable, present the even-aligned sync byte, return the cycle sync is visible.
    task automatic hunt_sync(output int s);
        step(1'b1, 1'b0, 1'b0);
        send_bits(64'hB8, 4, 1'b1);
        check("sync_pulse", rx_sync, 1);
        check("active_on_sync", rx_active, 1);
        s = cyc;
    endtask

    task automatic expect_byte(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic go_idle;
        step(1'b0, 1'b0, 1'b0);
        check("active_off", rx_active, 0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int          s;
        int          sync0;
        int          err0;
        logic [63:0] v;

        rst      = 1'b1;
        rx_hs_en = 1'b0;
        b1       = 1'b0;
        b2       = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rst_byte", {24'h0, rx_byte}, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_active", rx_active, 0);
        check("rst_sync", rx_sync, 0);
        check("rst_err", err_sot, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // 1. even-aligned sync, byte 5A
        sync0 = sync_cnt;
        hunt_sync(s);
        expect_byte(8'h5A, s + 4);
        v = 64'h5A;
        step(1'b1, v[0], v[1]);
        check("sync_one_cycle", rx_sync, 0);
        step(1'b1, v[2], v[3]);
        step(1'b1, v[4], v[5]);
        step(1'b1, v[6], v[7]);
        go_idle();
        check("t1_sync_count", sync_cnt - sync0, 1);

        // 2. odd-aligned sync: lead 0, sync, C3, 3C, pad 0
        v = {38'h0, 1'b0, 8'h3C, 8'hC3, 8'hB8, 1'b0};
        step(1'b1, 1'b0, 1'b0);
        send_bits(v, 5, 1'b1);
        check("odd_sync_pulse", rx_sync, 1);
        s = cyc;
        expect_byte(8'hC3, s + 4);
        expect_byte(8'h3C, s + 8);
        send_bits(v >> 10, 8, 1'b1);
        go_idle();

        // 3. no sync: timeout after 64 hunt cycles
        err0 = err_cnt;
        step(1'b1, 1'b0, 1'b0);
        send_bits(64'h0, 63, 1'b1);
        check("err_not_early", err_sot, 0);
        step(1'b1, 1'b0, 1'b0);
        check("err_pulse", err_sot, 1);
        check("err_not_active", rx_active, 0);
        sync0 = sync_cnt;
        send_bits(64'hB8B8, 8, 1'b1);
        check("err_held_no_sync", sync_cnt - sync0, 0);
        go_idle();
        check("err_count", err_cnt - err0, 1);

        // 4. early EoT two pairs into a byte: no strobe
        hunt_sync(s);
        send_bits(64'hFF, 2, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("eot_active_off", rx_active, 0);
        step(1'b0, 1'b0, 1'b0);
        check("eot_no_valid", rx_valid, 0);

        // 4b. EoT on the edge that completes a byte: strobe still delivered
        hunt_sync(s);
        expect_byte(8'hA5, s + 4);
        v = 64'hA5;
        send_bits(v, 3, 1'b1);
        step(1'b0, v[6], v[7]);
        check("eot3_active_off", rx_active, 0);
        check("eot3_valid", rx_valid, 1);
        step(1'b0, 1'b0, 1'b0);

        // 5. mid-packet reset while streaming FF
        hunt_sync(s);
        expect_byte(8'hFF, s + 4);
        send_bits(64'hFFFF, 6, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        check("mrst_byte", {24'h0, rx_byte}, 0);
        check("mrst_valid", rx_valid, 0);
        check("mrst_active", rx_active, 0);
        rst = 1'b0;
        hunt_sync(s);
        expect_byte(8'h81, s + 4);
        send_bits(64'h81, 4, 1'b1);
        go_idle();

        // 6. payload B8 after sync is data, no re-sync
        sync0 = sync_cnt;
        hunt_sync(s);
        expect_byte(8'hB8, s + 4);
        expect_byte(8'h12, s + 8);
        send_bits(64'h12B8, 8, 1'b1);
        go_idle();
        check("t6_sync_count", sync_cnt - sync0, 1);

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
